tlc_lamp_driver: RTL
====================

# tlc_lamp_driver

Output stage directly downstream of the traffic-light controller FSM. It takes the 2-bit highway and farm signal codes and drives six registered lamp outputs. It also acts as an independent conflict monitor: an unsafe, invalid or illegally sequenced code is never displayed. Instead the block latches a fault and flashes red on both roads until an operator clear.

## Interface
- BLINK_HALF, 25000000: flash half-period in Clk cycles (0.5 s at 50 MHz); must be ≥2.
- Clk  input  1  system clock, all logic on rising edge.
- Rst  input  1  reset, synchronous, active-high.
- highwaySignal  input  2  code from controller: green 00, yellow 01, red 10, 11 invalid.
- farmSignal  input  2  same encoding.
- FaultClr  input  1  operator fault clear, level-sampled.
- LampTest  input  1  lamp test request, level.
- hwyLamps  output  3  {red, yellow, green}, registered, 1 = lamp on.
- farmLamps  output  3  {red, yellow, green}, registered.
- Fault  output  1  sticky fault flag, registered.
- faultCode  output  2  first fault cause: 00 none, 01 conflict, 10 invalid code, 11 illegal transition.
- monState  output  2  monitor state, for debugging.

## Operation
- Monitor states: MON_RST 00, MON_RUN 01, MON_FLASH 10, MON_TEST 11.
- Fault checks apply to the inputs sampled in the current cycle and are evaluated only in RUN and TEST.
  - Invalid: either code equals 11.
  - Conflict: neither code is red.
  - Illegal transition: either road's code differs from its previous registered code, and the change is not one of G→Y, Y→R, R→G.
  - Priority when several checks fire: invalid > conflict > transition. Only the first fault is captured in faultCode.
- MON_RST:
  - Lamps show solid red on both roads (100/100).
  - prevHwy and prevFarm are loaded with red (10).
  - Next state is always RUN.
- MON_RUN:
  - If a fault is detected: go to FLASH, set Fault=1, load faultCode, reset the blink counter to 0 and the phase to on.
  - Else if LampTest=1: go to TEST.
  - Otherwise the lamps show the decoded codes (one-hot: G→001, Y→010, R→100). The prev registers are updated with the current codes.
- MON_TEST:
  - Lamps are all on (111/111).
  - Fault checking and prev updating continue as in RUN, and a fault still wins (go to FLASH).
  - LampTest=0 returns to RUN.
- MON_FLASH:
  - Both roads show red = blink phase; yellow and green are off.
  - The blink counter counts 0..BLINK_HALF-1. The phase toggles when the counter wraps.
  - If FaultClr=1 and both inputs equal red in the same cycle: go to RUN, clear Fault and faultCode to 00, load prev registers with red.
  - Otherwise stay in FLASH. FaultClr asserted while an input is non-red is ignored.
  - LampTest is ignored in FLASH.
- FaultClr is ignored outside FLASH.
- The blink counter width is $clog2(BLINK_HALF). It holds at 0 outside FLASH.

## Timing
- Rst=1 at an edge produces these values:
  - monState=00, hwyLamps=100, farmLamps=100.
  - Fault=0, faultCode=00, prev registers=10.
  - Blink counter 0, phase on.
- Rst overrides everything, including an in-progress flash or test.
- First edge with Rst=0: MON_RST→RUN, lamps still 100/100.
- Latency input→lamps is 1 cycle: codes sampled at edge N appear on the lamps after edge N.
- A faulty code sampled at edge N is never displayed. After edge N the lamps are 100/100 (flash phase on), and Fault=1 and monState=10 in the same cycle.
- Flash timing: red on for BLINK_HALF cycles, then off for BLINK_HALF cycles, repeating. The first on-period starts at the fault edge.
- FaultClr accepted at edge N: after edge N, monState=01, Fault=0, lamps 100/100. Normal decoding resumes with codes sampled at edge N+1.
- Simultaneous fault and LampTest in RUN: fault wins.

## Test plan
- Reset, then controller sequence R/R, G/R, Y/R, R/R, R/G, R/Y, R/R (one code pair per cycle, BLINK_HALF=4) → lamps follow with 1-cycle lag, Fault stays 0.
- In RUN drive hwy=00, farm=00 → next cycle Fault=1, faultCode=01, lamps 100/100. Red then toggles every 4 cycles: on 4 cycles, off 4 cycles.
- Drive hwy G→R directly (00 then 10) → faultCode=11, FLASH. A later farm=11 does not change faultCode.
- In FLASH assert FaultClr with hwy=00 → stays FLASH. Then FaultClr with both=10 → RUN, Fault=0, faultCode=00.
- LampTest=1 in RUN → lamps 111/111 next cycle. Inject hwy=11 during test → FLASH, faultCode=10. LampTest during FLASH has no effect.
- Rst asserted mid-flash → next cycle monState=00, Fault=0, lamps 100/100. The following cycle monState=01.

Source files
------------

// File: rtl/tlc_lamp_driver.sv
// ---------------------------------------------------------------------------
// tlc_lamp_driver
//
// Lamp output stage for the traffic-light controller, doubling as an
// independent conflict monitor. Controller codes are checked every cycle in
// RUN and TEST. A code that is invalid, conflicting or illegally sequenced
// never reaches the lamps. Instead a sticky fault is latched and both roads
// flash red until the operator clears it.
//
// Parameters
//   BLINK_HALF     flash half-period in Clk cycles (>= 2)
//
// Ports
//   Clk            system clock, rising edge
//   Rst            synchronous reset, active high
//   highwaySignal  controller code, highway road (00 G, 01 Y, 10 R, 11 bad)
//   farmSignal     controller code, farm road (same encoding)
//   FaultClr       operator fault clear (level, honoured only in FLASH)
//   LampTest       lamp test request (level)
//   hwyLamps       highway lamps {red, yellow, green}, registered
//   farmLamps      farm lamps {red, yellow, green}, registered
//   Fault          sticky fault flag, registered
//   faultCode      first fault cause: 00 none, 01 conflict, 10 invalid,
//                  11 illegal transition
//   monState       monitor state (00 RST, 01 RUN, 10 FLASH, 11 TEST)
// ---------------------------------------------------------------------------

// Per-road check and decode. Purely combinational.
//   code      code sampled this cycle
//   prev      last code accepted for this road
//   invalid   code is the unused 11 encoding
//   is_red    code is red
//   bad_step  code changed, and not along G->Y->R->G
//   lamps     one-hot {red, yellow, green} decode of code
module tlc_road_chk (
    input  logic [1:0] code,
    input  logic [1:0] prev,
    output logic       invalid,
    output logic       is_red,
    output logic       bad_step,
    output logic [2:0] lamps
);
    localparam logic [1:0] C_GRN = 2'b00;
    localparam logic [1:0] C_YEL = 2'b01;
    localparam logic [1:0] C_RED = 2'b10;

    logic step_ok;

    assign invalid = (code == 2'b11);
    assign is_red  = (code == C_RED);

    // Holding the same code is always fine; a change must follow the cycle.
    assign step_ok = (code == prev)
                   || ((prev == C_GRN) && (code == C_YEL))
                   || ((prev == C_YEL) && (code == C_RED))
                   || ((prev == C_RED) && (code == C_GRN));
    assign bad_step = !step_ok;

    always_comb begin
        lamps = 3'b100;
        case (code)
            C_GRN:   lamps = 3'b001;
            C_YEL:   lamps = 3'b010;
            C_RED:   lamps = 3'b100;
            default: lamps = 3'b100;
        endcase
    end
endmodule

module tlc_lamp_driver #(
    parameter int BLINK_HALF = 25000000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] highwaySignal,
    input  logic [1:0] farmSignal,
    input  logic       FaultClr,
    input  logic       LampTest,
    output logic [2:0] hwyLamps,
    output logic [2:0] farmLamps,
    output logic       Fault,
    output logic [1:0] faultCode,
    output logic [1:0] monState
);
    localparam int NUM_ROADS = 2;
    localparam int CW        = $clog2(BLINK_HALF);

    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);
    localparam logic [1:0]    C_RED    = 2'b10;
    localparam logic [2:0]    L_RED    = 3'b100;
    localparam logic [2:0]    L_ALL    = 3'b111;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_CONFLICT = 2'b01;
    localparam logic [1:0] FC_INVALID  = 2'b10;
    localparam logic [1:0] FC_STEP     = 2'b11;

    typedef enum logic [1:0] {
        MON_RST   = 2'b00,
        MON_RUN   = 2'b01,
        MON_FLASH = 2'b10,
        MON_TEST  = 2'b11
    } mon_t;

    mon_t                            state;
    logic [NUM_ROADS-1:0][1:0]       code_in;
    logic [NUM_ROADS-1:0][1:0]       prev_q;
    logic [NUM_ROADS-1:0]            inv;
    logic [NUM_ROADS-1:0]            red;
    logic [NUM_ROADS-1:0]            bad;
    logic [NUM_ROADS-1:0][2:0]       dec;
    logic [CW-1:0]                   blink_cnt;
    logic                            blink_on;
    logic [1:0]                      fault_det;

    // Road 0 is the highway, road 1 the farm road.
    assign code_in = {farmSignal, highwaySignal};

    for (genvar g = 0; g < NUM_ROADS; g++) begin : g_road
        tlc_road_chk u_chk (
            .code     (code_in[g]),
            .prev     (prev_q[g]),
            .invalid  (inv[g]),
            .is_red   (red[g]),
            .bad_step (bad[g]),
            .lamps    (dec[g])
        );
    end

    // Highest-priority cause wins: invalid, then conflict, then sequencing.
    always_comb begin
        fault_det = FC_NONE;
        if (|inv)
            fault_det = FC_INVALID;
        else if (!(|red))
            fault_det = FC_CONFLICT;
        else if (|bad)
            fault_det = FC_STEP;
    end

    assign monState = state;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= MON_RST;
            hwyLamps  <= L_RED;
            farmLamps <= L_RED;
            Fault     <= 1'b0;
            faultCode <= FC_NONE;
            prev_q    <= {C_RED, C_RED};
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            case (state)
                MON_RST: begin
                    state     <= MON_RUN;
                    hwyLamps  <= L_RED;
                    farmLamps <= L_RED;
                    prev_q    <= {C_RED, C_RED};
                    blink_cnt <= '0;
                    blink_on  <= 1'b1;
                end

                MON_RUN, MON_TEST: begin
                    if (fault_det != FC_NONE) begin
                        // Offending code is dropped; flash starts in the on phase.
                        state     <= MON_FLASH;
                        Fault     <= 1'b1;
                        faultCode <= fault_det;
                        blink_cnt <= '0;
                        blink_on  <= 1'b1;
                        hwyLamps  <= L_RED;
                        farmLamps <= L_RED;
                    end else begin
                        // Accepted codes become the reference for the next check,
                        // whether or not they are displayed.
                        prev_q <= code_in;
                        if (LampTest) begin
                            state     <= MON_TEST;
                            hwyLamps  <= L_ALL;
                            farmLamps <= L_ALL;
                        end else begin
                            state     <= MON_RUN;
                            hwyLamps  <= dec[0];
                            farmLamps <= dec[1];
                        end
                    end
                end

                MON_FLASH: begin
                    if (FaultClr && red[0] && red[1]) begin
                        state     <= MON_RUN;
                        Fault     <= 1'b0;
                        faultCode <= FC_NONE;
                        prev_q    <= {C_RED, C_RED};
                        blink_cnt <= '0;
                        blink_on  <= 1'b1;
                        hwyLamps  <= L_RED;
                        farmLamps <= L_RED;
                    end else if (blink_cnt == CNT_LAST) begin
                        // Wrap: the lamps take the new phase on the same edge.
                        blink_cnt <= '0;
                        blink_on  <= !blink_on;
                        hwyLamps  <= {!blink_on, 2'b00};
                        farmLamps <= {!blink_on, 2'b00};
                    end else begin
                        blink_cnt <= blink_cnt + CW'(1);
                        hwyLamps  <= {blink_on, 2'b00};
                        farmLamps <= {blink_on, 2'b00};
                    end
                end

                default: begin
                    state     <= MON_RST;
                    hwyLamps  <= L_RED;
                    farmLamps <= L_RED;
                end
            endcase
        end
    end
endmodule
